// File: rtl/inst_fetch.sv
// Instruction fetch unit: owns the PC, addresses the instruction ROM and presents one
// registered instruction to decode. Optional range check: INST_FETCH_FAULT_CHK_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          ROM_WORDS = 32
) (
    input  logic        Clk,
    input  logic        Clrn,
    output logic [31:0] Addr,
    input  logic [31:0] Inst,
    input  logic        Redirect,
    input  logic [31:0] Target,
    input  logic        Out_Ready,
    output logic        Out_Valid,
    output logic [31:0] Out_Inst,
    output logic [31:0] Out_PC,
    output logic [31:0] Out_PC4,
    output logic [15:0] Fetch_Cnt,
    output logic        Fault
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        out_valid_r, out_valid_s;
    logic [31:0] out_inst_r, out_inst_s;
    logic [31:0] out_pc_r, out_pc_s;
    logic [31:0] out_pc4_r, out_pc4_s;
    logic [15:0] fetch_cnt_r, fetch_cnt_s;
    logic        handshake_s;
    logic        capture_s;
    logic        fault_hit_s;

`ifdef INST_FETCH_FAULT_CHK_EN
    localparam logic [31:0] ROM_BYTES = 32'(4 * ROM_WORDS);

    logic fault_r, fault_s;
    logic target_ok_s;

    assign fault_hit_s = (pc_r >= ROM_BYTES);
    assign target_ok_s = ({Target[31:2], 2'b00} < ROM_BYTES);
    assign Fault       = fault_r;

    // Fault flag: set by an out-of-range capture attempt, cleared by an in-range redirect.
    always_comb begin
        fault_s = fault_r;
        if (Redirect) begin
            if (target_ok_s) begin
                fault_s = 1'b0;
            end else begin
                fault_s = fault_r;
            end
        end else if (capture_s && fault_hit_s) begin
            fault_s = 1'b1;
        end else begin
            fault_s = fault_r;
        end
    end

    // Fault flag register.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            fault_r <= 1'b0;
        end else begin
            fault_r <= fault_s;
        end
    end
`else
    assign fault_hit_s = 1'b0;
    assign Fault       = 1'b0;
`endif

    assign handshake_s = out_valid_r & Out_Ready;
    // HOLD only ever has Out_Valid set, so this also covers the back-to-back release.
    assign capture_s   = ((state_r == FETCH) || (state_r == HOLD)) && (!out_valid_r || Out_Ready);

    // Next-state, PC and output-register logic; redirect outranks capture and stall.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        out_valid_s = out_valid_r;
        out_inst_s  = out_inst_r;
        out_pc_s    = out_pc_r;
        out_pc4_s   = out_pc4_r;
        fetch_cnt_s = handshake_s ? (fetch_cnt_r + 16'd1) : fetch_cnt_r;
        if (Redirect) begin
            pc_s        = {Target[31:2], 2'b00};
            out_valid_s = 1'b0;
            state_s     = FETCH;
        end else if (capture_s && fault_hit_s) begin
            out_valid_s = 1'b0;
            state_s     = FAULT;
        end else if (capture_s) begin
            out_inst_s  = Inst;
            out_pc_s    = pc_r;
            out_pc4_s   = pc_r + 32'd4;
            out_valid_s = 1'b1;
            pc_s        = pc_r + 32'd4;
            state_s     = FETCH;
        end else begin
            case (state_r)
                BOOT:        state_s = FETCH;
                FETCH, HOLD: state_s = HOLD;
                FAULT:       state_s = FAULT;
                default:     state_s = BOOT;
            endcase
        end
    end

    // State, PC and output registers.
    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            state_r     <= BOOT;
            pc_r        <= {RESET_PC[31:2], 2'b00};
            out_valid_r <= 1'b0;
            out_inst_r  <= 32'd0;
            out_pc_r    <= 32'd0;
            out_pc4_r   <= 32'd4;
            fetch_cnt_r <= 16'd0;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            out_valid_r <= out_valid_s;
            out_inst_r  <= out_inst_s;
            out_pc_r    <= out_pc_s;
            out_pc4_r   <= out_pc4_s;
            fetch_cnt_r <= fetch_cnt_s;
        end
    end

    assign Addr      = pc_r;
    assign Out_Valid = out_valid_r;
    assign Out_Inst  = out_inst_r;
    assign Out_PC    = out_pc_r;
    assign Out_PC4   = out_pc4_r;
    assign Fetch_Cnt = fetch_cnt_r;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: per-cycle vector table plus an accepted-instruction
// scoreboard, a second instance for PC wrap-around, and a mid-run reset.
module tb_inst_fetch;

    logic        Clk = 1'b0;
    logic        Clrn;
    logic        Redirect;
    logic [31:0] Target;
    logic        Out_Ready;
    logic [31:0] Addr, Inst, Out_Inst, Out_PC, Out_PC4;
    logic        Out_Valid, Fault;
    logic [15:0] Fetch_Cnt;

    logic [31:0] w_addr, w_inst, w_out_inst, w_out_pc, w_out_pc4;
    logic        w_out_valid, w_fault;
    logic [15:0] w_fetch_cnt;
    logic        w_ready = 1'b1;
    logic        w_redirect = 1'b0;
    logic [31:0] w_target = 32'd0;

    logic [31:0] rom [0:31];

    always #5 Clk = ~Clk;

    assign Inst   = rom[Addr[6:2]];
    assign w_inst = rom[w_addr[6:2]];

    inst_fetch #(.RESET_PC(32'h0000_0000), .ROM_WORDS(32)) dut (
        .Clk(Clk), .Clrn(Clrn), .Addr(Addr), .Inst(Inst), .Redirect(Redirect),
        .Target(Target), .Out_Ready(Out_Ready), .Out_Valid(Out_Valid),
        .Out_Inst(Out_Inst), .Out_PC(Out_PC), .Out_PC4(Out_PC4),
        .Fetch_Cnt(Fetch_Cnt), .Fault(Fault)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFFC), .ROM_WORDS(32)) dut_wrap (
        .Clk(Clk), .Clrn(Clrn), .Addr(w_addr), .Inst(w_inst), .Redirect(w_redirect),
        .Target(w_target), .Out_Ready(w_ready), .Out_Valid(w_out_valid),
        .Out_Inst(w_out_inst), .Out_PC(w_out_pc), .Out_PC4(w_out_pc4),
        .Fetch_Cnt(w_fetch_cnt), .Fault(w_fault)
    );

    typedef struct {
        logic        rdy;
        logic        redir;
        logic [31:0] tgt;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic [15:0] e_cnt;
        logic        e_fault;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] acc_q[$];
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] rom_word(input logic [31:0] pc);
        return 32'h1000_0000 + {27'd0, pc[6:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic rdy, input logic redir, input logic [31:0] tgt,
                       input logic e_valid, input logic [31:0] e_pc, input logic [31:0] e_addr,
                       input logic [15:0] e_cnt, input logic e_fault);
        vec_t v;
        v.rdy = rdy; v.redir = redir; v.tgt = tgt; v.e_valid = e_valid;
        v.e_pc = e_pc; v.e_addr = e_addr; v.e_cnt = e_cnt; v.e_fault = e_fault;
        vecs.push_back(v);
    endtask

    initial begin
        logic [31:0] e;
        for (int n = 0; n < 32; n++) rom[n] = 32'h1000_0000 + 32'(n);

        //   rdy   redir tgt           valid pc            addr          cnt    fault
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        16'd0, 1'b0); // BOOT
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        16'd0, 1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        16'd1, 1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        16'd2, 1'b0);
        for (int k = 0; k < 3; k++)
            add(1'b0, 1'b0, 32'h0,    1'b1, 32'h8,        32'hC,        16'd2, 1'b0); // stall
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h10,       16'd3, 1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h10,       32'h14,       16'd4, 1'b0);
        add(1'b1, 1'b1, 32'h43,       1'b0, 32'h0,        32'h40,       16'd5, 1'b0); // redirect + handshake
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h40,       32'h44,       16'd5, 1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h40,       32'h44,       16'd5, 1'b0);
        add(1'b0, 1'b1, 32'h8,        1'b0, 32'h0,        32'h8,        16'd5, 1'b0); // flush in HOLD
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h8,        32'hC,        16'd5, 1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'hC,        32'h10,       16'd6, 1'b0);
        add(1'b1, 1'b1, 32'h7C,       1'b0, 32'h0,        32'h7C,       16'd7, 1'b0);
        add(1'b0, 1'b0, 32'h0,        1'b1, 32'h7C,       32'h80,       16'd7, 1'b0); // capture with ready low
`ifndef INST_FETCH_FAULT_CHK_EN
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h80,       32'h84,       16'd8, 1'b0); // ROM alias
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h84,       32'h88,       16'd9, 1'b0);
        acc_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h7C, 32'h80};
`else
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h80,       16'd8, 1'b1); // fault
        add(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        32'h80,       16'd8, 1'b1);
        add(1'b1, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0,        16'd8, 1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h0,        32'h4,        16'd8, 1'b0);
        add(1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h8,        16'd9, 1'b0);
        acc_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h8, 32'hC, 32'h7C, 32'h0};
`endif

        Clrn = 1'b0; Redirect = 1'b0; Target = 32'd0; Out_Ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_valid", 32'(Out_Valid), 32'd0);
        chk("rst_inst",  Out_Inst,  32'd0);
        chk("rst_pc",    Out_PC,    32'd0);
        chk("rst_pc4",   Out_PC4,   32'd4);
        chk("rst_cnt",   32'(Fetch_Cnt), 32'd0);
        chk("rst_addr",  Addr,      32'd0);
        chk("rst_fault", 32'(Fault), 32'd0);
        chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);
        Clrn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            Out_Ready = vecs[i].rdy;
            Redirect  = vecs[i].redir;
            Target    = vecs[i].tgt;
            if (Out_Valid && vecs[i].rdy) begin
                if (acc_q.size() == 0) begin
                    chk("sb_unexpected_accept", Out_PC, 32'hDEAD_BEEF);
                end else begin
                    e = acc_q.pop_front();
                    chk("sb_pc",   Out_PC,   e);
                    chk("sb_inst", Out_Inst, rom_word(e));
                    chk("sb_pc4",  Out_PC4,  e + 32'd4);
                end
            end
            @(posedge Clk);
            #1;
            chk($sformatf("v%0d_valid", i), 32'(Out_Valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_addr", i),  Addr,            vecs[i].e_addr);
            chk($sformatf("v%0d_cnt", i),   32'(Fetch_Cnt),  32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_fault", i), 32'(Fault),      32'(vecs[i].e_fault));
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d_pc", i),   Out_PC,   vecs[i].e_pc);
                chk($sformatf("v%0d_inst", i), Out_Inst, rom_word(vecs[i].e_pc));
            end
`ifndef INST_FETCH_FAULT_CHK_EN
            if (i == 1) begin
                chk("wrap_pc0",  w_out_pc,  32'hFFFF_FFFC);
                chk("wrap_pc40", w_out_pc4, 32'h0);
                chk("wrap_inst0", w_out_inst, 32'h1000_001F);
            end
            if (i == 2) begin
                chk("wrap_pc1",  w_out_pc,  32'h0);
                chk("wrap_pc41", w_out_pc4, 32'h4);
            end
`endif
        end
        chk("sb_drained", 32'(acc_q.size()), 32'd0);

        Redirect = 1'b0; Out_Ready = 1'b1;
        repeat (2) @(posedge Clk);
        #3;
        Clrn = 1'b0;
        #1;
        chk("midrst_valid", 32'(Out_Valid), 32'd0);
        chk("midrst_cnt",   32'(Fetch_Cnt), 32'd0);
        chk("midrst_addr",  Addr,           32'd0);
        chk("midrst_pc4",   Out_PC4,        32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction fetch unit that initiates every access to the combinational instruction ROM.
- Holds the PC, drives the ROM word address and captures the returned instruction into a one-entry output register.
- Hands the instruction to decode with a valid/ready handshake, honouring decode stalls and branch/jump redirects.
- Sits between the PC/next-PC logic and the decode stage of the CPU.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ROM_WORDS, 32, number of 32-bit words in the instruction ROM; the legal byte range is 0 to 4*ROM_WORDS-1.

Ports:
- Clk  input  1  system clock, rising edge.
- Clrn  input  1  asynchronous active-low reset.
- Addr  output  32  byte address to the instruction ROM; always equals the PC register.
- Inst  input  32  ROM read data, valid in the same cycle as Addr.
- Redirect  input  1  branch/jump taken; loads Target into the PC.
- Target  input  32  redirect byte address.
- Out_Ready  input  1  decode can accept an instruction this cycle.
- Out_Valid  output  1  Out_Inst/Out_PC hold a valid instruction.
- Out_Inst  output  32  captured instruction.
- Out_PC  output  32  address of Out_Inst.
- Out_PC4  output  32  Out_PC+4, modulo 2^32.
- Fetch_Cnt  output  16  count of handshakes completed (Out_Valid and Out_Ready both high); wraps.
- Fault  output  1  address fault flag. Present only with the optional feature; tied to 0 otherwise.

Behaviour:
- Reset (Clrn=0, asynchronous):
  - PC=RESET_PC with bits [1:0] forced to 0.
  - Out_Valid=0, Out_Inst=0, Out_PC=0, Out_PC4=4, Fetch_Cnt=0, Fault=0.
  - State=BOOT.
- States: BOOT, FETCH, HOLD, FAULT (FAULT is reachable only with the macro).
- BOOT:
  - Lasts exactly one cycle after Clrn deasserts. Out_Valid=0, PC unchanged.
  - Next state is FETCH, or applies the Redirect rules below if Redirect=1.
- Capture condition: state FETCH, and either Out_Valid=0 or Out_Ready=1.
- On capture:
  - Out_Inst<=Inst, Out_PC<=PC, Out_PC4<=PC+4, Out_Valid<=1.
  - PC<=PC+4; 32'hFFFF_FFFC wraps to 0.
- Stall: Out_Valid=1 and Out_Ready=0:
  - State goes to HOLD. PC, Addr and all Out_* stay stable.
  - Stay in HOLD until Out_Ready=1. In that cycle the handshake completes and a capture happens in the same cycle (back-to-back, no bubble). State returns to FETCH.
- Throughput: 1 instruction/cycle while Out_Ready=1. Latency from PC load to Out_Valid is 1 cycle.
- Redirect has priority over capture and HOLD in every state:
  - PC<=Target with bits [1:0] forced to 0. Out_Valid<=0 (flush). State<=FETCH.
  - The first redirected instruction is valid 2 cycles after Redirect.
  - If Out_Valid=1 and Out_Ready=1 in the Redirect cycle, that handshake still completes and counts in Fetch_Cnt.
- Fetch_Cnt increments by 1 on every completed handshake, 16'hFFFF to 0.
- Reset mid-operation: all state is cleared immediately. Any instruction in flight is discarded with no handshake.

Optional Feature:
- Macro: INST_FETCH_FAULT_CHK_EN.
- With the macro:
  - If PC >= 4*ROM_WORDS when a capture would occur, no capture happens.
  - Fault<=1, Out_Valid<=0, state<=FAULT, and the PC is frozen.
  - FAULT is left only by Redirect to an in-range Target (Fault<=0, state FETCH) or by reset.
  - A Redirect to an out-of-range Target loads the PC and faults on the next capture attempt.
- Without the macro:
  - No range check; Fault is tied to 0.
  - The PC runs freely and the ROM aliases on Addr[6:2].

Test Plan:
- Reset release, Out_Ready=1, ROM word n = 32'h1000_0000+n -> Out_Valid first 1 in the 2nd cycle after reset, with Out_Inst=32'h1000_0000, Out_PC=0. Then one instruction per cycle: PC 4, 8, C, ... and Fetch_Cnt 1, 2, 3, ...
- Out_Ready=0 for 3 cycles while Out_Inst=32'h1000_0002 -> Out_*, Addr=32'h0C and Fetch_Cnt all stable. When Out_Ready=1, word 2 is accepted and word 3 is presented the next cycle.
- Redirect=1, Target=32'h0000_0043 while Out_Valid=1, Out_Ready=1 -> the handshake counts, Out_Valid=0 next cycle, Addr=32'h40, then Out_Inst=32'h1000_0010 with Out_PC=32'h40.
- Redirect and Out_Ready=0 in the same HOLD cycle -> flush wins: Out_Valid=0, PC=Target, Fetch_Cnt unchanged.
- RESET_PC=32'hFFFF_FFFC, macro off -> Out_PC sequence FFFF_FFFC, 0000_0000; Out_PC4 of the first instruction equals 0.
- Macro on, run to PC=32'h80 with ROM_WORDS=32 -> Fault=1, Out_Valid=0, Addr held at 32'h80. Redirect to 32'h0 -> Fault=0, and Out_Inst=32'h1000_0000 two cycles later.
